// File: rtl/fwrisc_mem_op_pkg.sv
// fwrisc load/store unit: opcode constants, FSM states
// and opcode decode helpers shared by the LSU files.
package fwrisc_mem_op_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd2,
    OP_LD  = 4'd3,
    OP_LBU = 4'd4,
    OP_LHU = 4'd5,
    OP_LWU = 4'd6,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10,
    OP_SD  = 4'd11
  } mem_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } lsu_state_e;

  // Access size in bytes; low two opcode bits encode it.
  function automatic logic [3:0] op_size(logic [3:0] op);
    logic [3:0] sz;
    unique case (op[1:0])
      2'd0:    sz = 4'd1;
      2'd1:    sz = 4'd2;
      2'd2:    sz = 4'd4;
      default: sz = 4'd8;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_store(logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic op_is_signed(logic [3:0] op);
    return !op[3] && !op[2];
  endfunction

  // Doubleword and unsigned-word ops need a 64-bit bus.
  function automatic logic op_legal(logic [3:0] op, int dw);
    logic ok;
    unique case (op)
      OP_LB, OP_LH, OP_LW,
      OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW:    ok = 1'b1;
      OP_LD, OP_LWU, OP_SD:   ok = (dw >= 64);
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fwrisc_mem_lsu_if.sv
// fwrisc LSU bundle: execute-stage request/ack plus
// the external data bus, with LSU and environment views.
interface fwrisc_mem_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_op;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  ack_valid;
  logic [DATA_WIDTH-1:0] ack_data;
  logic                  ack_err;
  logic                  dvalid;
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] dwdata;
  logic [NB-1:0]         dwstb;
  logic                  dwrite;
  logic [DATA_WIDTH-1:0] drdata;
  logic                  dready;

  modport slave (
    input  req_valid, req_addr, req_op, req_data,
    input  drdata, dready,
    output req_ready, ack_valid, ack_data, ack_err,
    output dvalid, daddr, dwdata, dwstb, dwrite
  );

  modport master (
    output req_valid, req_addr, req_op, req_data,
    output drdata, dready,
    input  req_ready, ack_valid, ack_data, ack_err,
    input  dvalid, daddr, dwdata, dwstb, dwrite
  );

endinterface

// File: rtl/fwrisc_mem_lane_align.sv
// fwrisc LSU lane alignment: store strobes and lane
// replication, load extract and sign/zero extension.
import fwrisc_mem_op_pkg::*;

module fwrisc_mem_lane_align #(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [3:0]            op_i,
  input  logic [OFFW-1:0]       off_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  output logic [NB-1:0]         stb_o,
  output logic [DATA_WIDTH-1:0] st_data_o,
  output logic [DATA_WIDTH-1:0] ld_data_o
);

  int                    sz;
  logic [NB-1:0]         mask;
  logic [DATA_WIDTH-1:0] sh;
  logic                  sx;

  // Access size clamped to the bus so indices stay in range.
  always_comb begin
    sz = int'(op_size(op_i));
    if (sz > NB) sz = NB;
  end

  // Byte mask of the access, moved to its lane.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++) mask[i] = (i < sz);
    stb_o = mask << off_i;
  end

  // Low bytes of the store value repeated on every lane.
  always_comb begin
    st_data_o = '0;
    for (int i = 0; i < NB; i++)
      st_data_o[8*i +: 8] = st_data_i[8*(i & (sz - 1)) +: 8];
  end

  // Shift the addressed bytes down, then extend.
  always_comb begin
    sh = ld_data_i >> {off_i, 3'b000};
    sx = op_is_signed(op_i) & sh[8*sz-1];
    ld_data_o = '0;
    for (int b = 0; b < DATA_WIDTH; b++)
      ld_data_o[b] = (b < 8*sz) ? sh[b] : sx;
  end

endmodule

// File: rtl/fwrisc_mem_lsu.sv
// fwrisc load/store unit: accepts execute-stage requests,
// runs one bus access each and returns a one-cycle ack.
import fwrisc_mem_op_pkg::*;

module fwrisc_mem_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  fwrisc_mem_lsu_if.slave bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e            state_q, state_d;
  logic                  dvalid_q, dvalid_d;
  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
  logic [DATA_WIDTH-1:0] dwdata_q, dwdata_d;
  logic [NB-1:0]         dwstb_q, dwstb_d;
  logic                  dwrite_q, dwrite_d;
  logic                  ack_valid_q, ack_valid_d;
  logic [DATA_WIDTH-1:0] ack_data_q, ack_data_d;
  logic                  ack_err_q, ack_err_d;
  logic [3:0]            op_q, op_d;
  logic [OFFW-1:0]       off_q, off_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [3:0]            al_op;
  logic [OFFW-1:0]       al_off;
  logic [NB-1:0]         al_stb;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_rdata;
  logic [3:0]            req_sz;
  logic [2:0]            req_lo;
  logic                  req_ok;
  logic                  tmo_hit;

  // The aligner serves the request in IDLE, the held op in ACCESS.
  assign al_op  = (state_q == ST_ACCESS) ? op_q : bus.req_op;
  assign al_off = (state_q == ST_ACCESS) ? off_q
                                         : bus.req_addr[OFFW-1:0];

  fwrisc_mem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .op_i      (al_op),
    .off_i     (al_off),
    .st_data_i (bus.req_data),
    .ld_data_i (bus.drdata),
    .stb_o     (al_stb),
    .st_data_o (al_wdata),
    .ld_data_o (al_rdata)
  );

  assign req_sz = op_size(bus.req_op);
  assign req_lo = bus.req_addr[2:0] & 3'(req_sz - 4'd1);
  assign req_ok = op_legal(bus.req_op, DATA_WIDTH)
                  && (req_lo == 3'd0);
  assign tmo_hit = (TIMEOUT > 0)
                   && (cnt_q == CW'(TIMEOUT - 1));

  // Next state, registered bus outputs and ack pulse.
  always_comb begin
    state_d     = state_q;
    dvalid_d    = dvalid_q;
    daddr_d     = daddr_q;
    dwdata_d    = dwdata_q;
    dwstb_d     = dwstb_q;
    dwrite_d    = dwrite_q;
    ack_valid_d = 1'b0;
    ack_data_d  = '0;
    ack_err_d   = 1'b0;
    op_d        = op_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && !req_ok) begin
          ack_valid_d = 1'b1;
          ack_err_d   = 1'b1;
        end else if (bus.req_valid) begin
          state_d  = ST_ACCESS;
          dvalid_d = 1'b1;
          daddr_d  = {bus.req_addr[ADDR_WIDTH-1:OFFW],
                      {OFFW{1'b0}}};
          dwrite_d = op_is_store(bus.req_op);
          dwstb_d  = op_is_store(bus.req_op) ? al_stb : '0;
          dwdata_d = op_is_store(bus.req_op) ? al_wdata : '0;
          op_d     = bus.req_op;
          off_d    = bus.req_addr[OFFW-1:0];
          cnt_d    = '0;
        end
      end
      ST_ACCESS: begin
        if (bus.dready) begin
          state_d     = ST_IDLE;
          dvalid_d    = 1'b0;
          ack_valid_d = 1'b1;
          ack_data_d  = op_is_store(op_q) ? '0 : al_rdata;
        end else if (tmo_hit) begin
          state_d     = ST_IDLE;
          dvalid_d    = 1'b0;
          ack_valid_d = 1'b1;
          ack_err_d   = 1'b1;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dvalid_q    <= 1'b0;
      daddr_q     <= '0;
      dwdata_q    <= '0;
      dwstb_q     <= '0;
      dwrite_q    <= 1'b0;
      ack_valid_q <= 1'b0;
      ack_data_q  <= '0;
      ack_err_q   <= 1'b0;
      op_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      dvalid_q    <= dvalid_d;
      daddr_q     <= daddr_d;
      dwdata_q    <= dwdata_d;
      dwstb_q     <= dwstb_d;
      dwrite_q    <= dwrite_d;
      ack_valid_q <= ack_valid_d;
      ack_data_q  <= ack_data_d;
      ack_err_q   <= ack_err_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.ack_valid = ack_valid_q;
  assign bus.ack_data  = ack_data_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.dvalid    = dvalid_q;
  assign bus.daddr     = daddr_q;
  assign bus.dwdata    = dwdata_q;
  assign bus.dwstb     = dwstb_q;
  assign bus.dwrite    = dwrite_q;

endmodule

// File: tb/tb_fwrisc_mem_lsu.sv
// fwrisc LSU bench: 32-bit (no timeout) and 64-bit
// (timeout 4) instances against a behavioural model.
module tb_fwrisc_mem_lsu;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  fwrisc_mem_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if32 ();
  fwrisc_mem_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) if64 ();

  fwrisc_mem_lsu #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)
  ) u32 (
    .clock(clock), .reset_n(reset_n), .bus(if32)
  );

  fwrisc_mem_lsu #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(4)
  ) u64 (
    .clock(clock), .reset_n(reset_n), .bus(if64)
  );

  typedef struct {
    logic        req_ready;
    logic        dvalid;
    logic [63:0] daddr;
    logic [63:0] dwdata;
    logic [63:0] dwstb;
    logic        dwrite;
    logic        ack_valid;
    logic [63:0] ack_data;
    logic        ack_err;
  } obs_t;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned m_trunc(
      longint unsigned x, int dw);
    return (dw == 64) ? x : (x & 64'hFFFF_FFFF);
  endfunction

  function automatic int m_size(int op);
    return 1 << (op % 4);
  endfunction

  function automatic bit m_legal(int op, int dw);
    if (op == 7 || op > 11) return 1'b0;
    if (dw == 32 && (op == 3 || op == 6 || op == 11))
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint unsigned m_rep(
      longint unsigned d, int sz, int dw);
    longint unsigned v, r;
    v = (sz == 8) ? d : d % (64'd1 << (8 * sz));
    r = 0;
    for (int k = 0; k < (dw / 8) / sz; k++)
      r = r | (v << (8 * sz * k));
    return m_trunc(r, dw);
  endfunction

  function automatic longint unsigned m_load(
      longint unsigned rd, int off, int op, int dw);
    longint unsigned v;
    int sz;
    sz = m_size(op);
    v = rd >> (8 * off);
    if (sz < 8) begin
      v = v % (64'd1 << (8 * sz));
      if (op <= 3 && v >= (64'd1 << (8 * sz - 1)))
        v = v - (64'd1 << (8 * sz));
    end
    return m_trunc(v, dw);
  endfunction

  // ---------------- DUT access ----------------
  task automatic snap(input int s, output obs_t o);
    if (s != 0) begin
      o.req_ready = if64.req_ready;
      o.dvalid    = if64.dvalid;
      o.daddr     = 64'(if64.daddr);
      o.dwdata    = if64.dwdata;
      o.dwstb     = 64'(if64.dwstb);
      o.dwrite    = if64.dwrite;
      o.ack_valid = if64.ack_valid;
      o.ack_data  = if64.ack_data;
      o.ack_err   = if64.ack_err;
    end else begin
      o.req_ready = if32.req_ready;
      o.dvalid    = if32.dvalid;
      o.daddr     = 64'(if32.daddr);
      o.dwdata    = 64'(if32.dwdata);
      o.dwstb     = 64'(if32.dwstb);
      o.dwrite    = if32.dwrite;
      o.ack_valid = if32.ack_valid;
      o.ack_data  = 64'(if32.ack_data);
      o.ack_err   = if32.ack_err;
    end
  endtask

  task automatic drv_req(input int s, input logic v,
                         input logic [31:0] a, input logic [3:0] op,
                         input logic [63:0] d);
    if (s != 0) begin
      if64.req_valid = v; if64.req_addr = a;
      if64.req_op = op;   if64.req_data = d;
    end else begin
      if32.req_valid = v; if32.req_addr = a;
      if32.req_op = op;   if32.req_data = d[31:0];
    end
  endtask

  task automatic drv_bus(input int s, input logic rdy,
                         input logic [63:0] rd);
    if (s != 0) begin
      if64.dready = rdy; if64.drdata = rd;
    end else begin
      if32.dready = rdy; if32.drdata = rd[31:0];
    end
  endtask

  // One request; dready rises in ACCESS cycle number dly.
  task automatic xact(input int s, input int op,
                      input logic [31:0] addr, input logic [63:0] data,
                      input logic [63:0] rd, input int dly);
    int dw, nb, tmo, sz, off, ncyc;
    bit legal, abort, st;
    longint unsigned e_ld, e_stb;
    obs_t o;
    dw = (s != 0) ? 64 : 32;
    nb = dw / 8;
    tmo = (s != 0) ? 4 : 0;
    sz = m_size(op);
    off = int'(addr % nb);
    legal = m_legal(op, dw) && (addr % sz == 0);
    st = (op >= 8);
    @(negedge clock);
    drv_bus(s, 1'($urandom_range(0, 1)), {$urandom, $urandom});
    drv_req(s, 1'b1, addr, 4'(op), data);
    snap(s, o);
    chk("req_ready_idle", 64'(o.req_ready), 1);
    @(posedge clock); #1;
    drv_req(s, 1'b0, '0, '0, '0);
    drv_bus(s, 1'b0, '0);
    snap(s, o);
    if (!legal) begin
      chk("err_no_dvalid", 64'(o.dvalid), 0);
      chk("err_ack_valid", 64'(o.ack_valid), 1);
      chk("err_ack_err", 64'(o.ack_err), 1);
      chk("err_ack_data", o.ack_data, 0);
      @(posedge clock); #1;
      snap(s, o);
      chk("err_ack_pulse", 64'(o.ack_valid), 0);
      chk("err_no_dvalid2", 64'(o.dvalid), 0);
    end else begin
      e_stb = st ? (((64'd1 << sz) - 1) << off) : 0;
      chk("acc_dvalid", 64'(o.dvalid), 1);
      chk("acc_daddr", o.daddr, 64'(addr - addr % nb));
      chk("acc_dwrite", 64'(o.dwrite), 64'(st));
      chk("acc_dwstb", o.dwstb, e_stb);
      if (st) chk("acc_dwdata", o.dwdata, m_rep(data, sz, dw));
      chk("acc_no_ack", 64'(o.ack_valid), 0);
      chk("acc_not_ready", 64'(o.req_ready), 0);
      abort = (tmo > 0) && (dly >= tmo);
      ncyc = abort ? tmo : dly + 1;
      for (int c = 0; c < ncyc; c++) begin
        if (c > 0) begin
          snap(s, o);
          chk("acc_dvalid_held", 64'(o.dvalid), 1);
          chk("acc_daddr_held", o.daddr, 64'(addr - addr % nb));
        end
        drv_bus(s, 1'(c == dly),
                (c == dly) ? rd : {$urandom, $urandom});
        @(posedge clock); #1;
      end
      drv_bus(s, 1'b0, '0);
      snap(s, o);
      e_ld = (abort || st) ? 0
             : m_load(m_trunc(rd, dw), off, op, dw);
      chk("ack_valid", 64'(o.ack_valid), 1);
      chk("ack_err", 64'(o.ack_err), 64'(abort));
      chk("ack_data", o.ack_data, e_ld);
      chk("ack_dvalid_low", 64'(o.dvalid), 0);
      chk("ack_req_ready", 64'(o.req_ready), 1);
      @(posedge clock); #1;
      snap(s, o);
      chk("ack_pulse", 64'(o.ack_valid), 0);
    end
  endtask

  initial begin
    obs_t o;
    logic [63:0] rdw;
    drv_req(0, 1'b0, '0, '0, '0);
    drv_req(1, 1'b0, '0, '0, '0);
    drv_bus(0, 1'b0, '0);
    drv_bus(1, 1'b0, '0);
    repeat (2) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      snap(s, o);
      chk("rst_dvalid", 64'(o.dvalid), 0);
      chk("rst_daddr", o.daddr, 0);
      chk("rst_dwdata", o.dwdata, 0);
      chk("rst_dwstb", o.dwstb, 0);
      chk("rst_dwrite", 64'(o.dwrite), 0);
      chk("rst_ack_valid", 64'(o.ack_valid), 0);
      chk("rst_ack_data", o.ack_data, 0);
      chk("rst_ack_err", 64'(o.ack_err), 0);
      chk("rst_req_ready", 64'(o.req_ready), 1);
    end
    reset_n = 1'b1;

    // Directed steps
    xact(0, 8, 32'h1003, 64'hA5, 64'h0, 0);
    xact(0, 1, 32'h2002, 64'h0, 64'h8001_1234, 1);
    xact(0, 5, 32'h2002, 64'h0, 64'h8001_1234, 2);
    xact(0, 2, 32'h3001, 64'h0, 64'h0, 0);
    xact(0, 3, 32'h3000, 64'h0, 64'h0, 0);
    xact(0, 13, 32'h3000, 64'h0, 64'h0, 0);
    xact(1, 11, 32'h8, 64'h0123_4567_89AB_CDEF, 64'h0, 0);
    xact(1, 6, 32'h4, 64'h0, 64'hDEAD_BEEF_0000_0000, 0);
    xact(1, 3, 32'h10, 64'h0, 64'h0, 10);
    xact(1, 3, 32'h10, 64'h0, 64'hFEDC_BA98_7654_3210, 3);
    xact(1, 0, 32'h17, 64'h0, 64'h80FF_0000_0000_0000, 2);

    // Back-to-back SW then LW with dready tied high
    rdw = 64'(32'h9ABC_DEF0);
    @(negedge clock);
    drv_bus(0, 1'b1, rdw);
    drv_req(0, 1'b1, 32'h100, 4'd10, 64'h1122_3344);
    @(posedge clock); #1;
    drv_req(0, 1'b0, '0, '0, '0);
    snap(0, o);
    chk("b2b_sw_dvalid", 64'(o.dvalid), 1);
    chk("b2b_sw_dwrite", 64'(o.dwrite), 1);
    @(posedge clock); #1;
    snap(0, o);
    chk("b2b_sw_ack", 64'(o.ack_valid), 1);
    chk("b2b_sw_ready", 64'(o.req_ready), 1);
    chk("b2b_sw_err", 64'(o.ack_err), 0);
    drv_req(0, 1'b1, 32'h104, 4'd2, '0);
    @(posedge clock); #1;
    drv_req(0, 1'b0, '0, '0, '0);
    snap(0, o);
    chk("b2b_lw_dvalid", 64'(o.dvalid), 1);
    chk("b2b_lw_dwrite", 64'(o.dwrite), 0);
    chk("b2b_lw_daddr", o.daddr, 64'h104);
    chk("b2b_lw_noack", 64'(o.ack_valid), 0);
    @(posedge clock); #1;
    drv_bus(0, 1'b0, '0);
    snap(0, o);
    chk("b2b_lw_ack", 64'(o.ack_valid), 1);
    chk("b2b_lw_data", o.ack_data, m_load(rdw, 0, 2, 32));

    // Reset pulsed in the middle of an access
    @(negedge clock);
    drv_req(0, 1'b1, 32'h4000, 4'd2, '0);
    @(posedge clock); #1;
    drv_req(0, 1'b0, '0, '0, '0);
    snap(0, o);
    chk("rst_mid_pre", 64'(o.dvalid), 1);
    #2 reset_n = 1'b0;
    #1 snap(0, o);
    chk("rst_mid_dvalid", 64'(o.dvalid), 0);
    chk("rst_mid_ack", 64'(o.ack_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_bus(0, 1'b1, '1);
      @(posedge clock); #1;
      snap(0, o);
      chk("rst_post_ack", 64'(o.ack_valid), 0);
      chk("rst_post_dvalid", 64'(o.dvalid), 0);
    end
    drv_bus(0, 1'b0, '0);

    // Randomized requests on both widths
    for (int i = 0; i < 60; i++) begin
      int s, op, sz;
      logic [31:0] a;
      s = i % 2;
      op = int'($urandom_range(0, 15));
      sz = m_size(op);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - a % sz;
      xact(s, op, a, {$urandom, $urandom},
           {$urandom, $urandom}, int'($urandom_range(0, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
